dmem_arbiter: RTL and testbench
===============================

// Module: dmem_arbiter
// PURPOSE
//  Two-master arbiter in front of the single-port, word-organised data memory.
//  - m0: CPU load/store unit. m1: loader/DMA port, with a bounded bus lock.
//  - Drives the memory's W_en/R_en/addr/RW_type/din combinationally from the winner.
//  - Registers the memory's combinational dout and returns it one cycle later.
// PARAMETERS
//  LOCK_MAX  16  max consecutive granted cycles m1 may hold the lock while m0 waits
//  CNT_W      5  lock counter width; must satisfy 2**CNT_W > LOCK_MAX
// PORTS
//  clk          in   1   single clock; all state updates on posedge
//  rst_n        in   1   reset, synchronous, active-low
//  m0_req       in   1   m0 access request, held until m0_gnt
//  m0_we        in   1   1=store, 0=load
//  m0_addr      in   32  byte address
//  m0_rw_type   in   3   [1:0] 00=B 01=H 10=W; [2]=1 unsigned load
//  m0_wdata     in   32  store data, right-aligned
//  m0_gnt       out  1   request accepted this cycle (combinational)
//  m0_rvalid    out  1   load data valid (registered; 1 cycle after gnt)
//  m0_rdata     out  32  load data, already extended by the memory
//  m0_err       out  1   misaligned-access flag, valid with rvalid/ack (ALIGN_CHK_EN only)
//  m1_*         --   --  same set as m0_*, plus:
//  m1_lock      in   1   keep the grant on m1 on following cycles (burst)
//  mem_W_en     out  1   to memory W_en
//  mem_R_en     out  1   to memory R_en
//  mem_addr     out  32  to memory addr
//  mem_RW_type  out  3   to memory RW_type
//  mem_din      out  32  to memory din
//  mem_dout     in   32  from memory dout (combinational read)
// BEHAVIOUR
//  - Reset (rst_n=0 at posedge): state=ARB_P0, lock_cnt=0, mx_rvalid=0, mx_rdata=0,
//    mx_err=0. While rst_n=0: mx_gnt=0, mem_W_en=0, mem_R_en=0.
//  - At most one gnt per cycle. No grant: mem_W_en=mem_R_en=0, mem_addr/RW_type/din=0.
//  - Granted master drives the mem_* outputs; mem_W_en=we, mem_R_en=~we.
//    Store commits at the grant edge. Load: mem_dout latched at the grant edge,
//    mx_rvalid=1 for exactly one cycle. Stores produce no rvalid.
//  - Throughput: one access per cycle. Back-to-back grants to the same master are allowed.
//  - FSM states and transitions:
//    ARB_P0: m0 has priority. Grant m0 -> ARB_P1. Grant m1 with m1_lock -> ARB_LK.
//            Grant m1 without lock -> ARB_P0.
//    ARB_P1: m1 has priority. Grant m1 with lock -> ARB_LK. Grant m1 without lock -> ARB_P0.
//            Grant m0 (m1 idle) -> ARB_P1.
//    ARB_LK: m1 owns the bus. While m1_req=1, grant m1 and lock_cnt++.
//            - m1_lock=0 or m1_req=0 -> ARB_P0, lock_cnt=0. A lone m0_req in that
//              cycle is granted.
//            - lock_cnt==LOCK_MAX with m0_req=1: forced release. Grant m0 this cycle,
//              m1 waits, lock_cnt=0, -> ARB_P1.
//            - lock_cnt saturates at LOCK_MAX while m0 is idle.
//  - No master is skipped twice in a row when both request (except in ARB_LK, bounded by LOCK_MAX).
//  - Requests are not queued. A master must hold req with stable fields until gnt.
//  - Reset mid-access: a pending rvalid is dropped, and the in-flight load is lost.
//    A store granted in the reset cycle is suppressed (enables forced to 0).
// CONFIGURATION
//  ALIGN_CHK_EN defined:
//   - Halfword with addr[0]=1 or word with addr[1:0]!=0 is still granted, but
//     mem_W_en=mem_R_en=0.
//   - Next cycle: rvalid=1 (also for stores), err=1, rdata=0.
//  ALIGN_CHK_EN undefined:
//   - Access passes through unchanged; the memory uses its own lane/word selection.
//   - mx_err tied to 0.
// STRUCTURE
//  - define.v holds the RW_type encodings (`RW_B/`RW_H/`RW_W, unsigned bit), the
//    FSM state codes ARB_P0/ARB_P1/ARB_LK, and `zeroword.
//  - One sub-module, rr_arb2: combinational 2-way priority pick from (req0, req1, state, cnt_hit).
//  - Top holds the FSM, lock counter, mux and response registers.
// TESTING
//  - Reset then m0 load W @0x10 with RAM[4]=0xDEADBEEF -> m0_gnt same cycle;
//    next cycle m0_rvalid=1, m0_rdata=0xDEADBEEF.
//  - m0 and m1 requesting every cycle, no lock -> grants alternate m0,m1,m0,...; the
//    first grant after reset goes to m0.
//  - m1 locked burst of 40 stores with m0_req=1 throughout -> m1 is granted 16 cycles,
//    then m0 1 cycle, then m1 16 more; m1 never holds more than LOCK_MAX consecutive
//    grants while m0 waits.
//  - m1 store B 0xAA @0x21 and m0 load BU @0x21 in the same cycle -> m0 wins;
//    rdata=old byte; m1 is granted next cycle; a re-read returns 0x000000AA.
//  - ALIGN_CHK_EN: m0 load W @0x22 -> mem_R_en=0; next cycle rvalid=1, err=1, rdata=0.
//    Without the macro: err=0.
//  - rst_n=0 for one cycle while m0 load pending -> no rvalid; gnt=0 during reset;
//    FSM returns to ARB_P0.

Source files
------------

// File: rtl/dmem_arbiter_pkg.sv
// Shared types and encodings for the two-master data-memory arbiter.
package dmem_arbiter_pkg;

  localparam int unsigned DATA_W       = 32;
  localparam int unsigned ADDR_W       = 32;
  localparam int unsigned RWT_W        = 3;
  localparam int unsigned LOCK_MAX_DEF = 16;
  localparam int unsigned CNT_W_DEF    = 5;

  // Access size in rw_type[1:0]; rw_type[2] selects zero-extension on loads
  localparam logic [1:0] RW_B = 2'b00;
  localparam logic [1:0] RW_H = 2'b01;
  localparam logic [1:0] RW_W = 2'b10;

  localparam logic [DATA_W-1:0] ZERO_WORD = '0;

  typedef enum logic [1:0] {
    ARB_P0 = 2'd0,
    ARB_P1 = 2'd1,
    ARB_LK = 2'd2
  } arb_state_e;

  typedef struct packed {
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [RWT_W-1:0]  rw_type;
    logic [DATA_W-1:0] wdata;
  } mem_req_t;

  // True when the byte address does not sit on a boundary of the access size
  function automatic logic misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
    case (size)
      RW_B:    return 1'b0;
      RW_H:    return addr_lo[0];
      RW_W:    return addr_lo != 2'b00;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/dmem_arbiter_rr_arb2.sv
// Combinational two-way pick: priority follows the arbiter state, with a
// forced hand-back to m0 once the m1 lock budget is spent.
module rr_arb2
  import dmem_arbiter_pkg::*;
(
  input  logic       req0,
  input  logic       req1,
  input  arb_state_e state,
  input  logic       cnt_hit,
  output logic       gnt0_c,
  output logic       gnt1_c
);

  always_comb begin
    gnt0_c = 1'b0;
    gnt1_c = 1'b0;
    case (state)
      ARB_P1: begin
        if (req1)      gnt1_c = 1'b1;
        else if (req0) gnt0_c = 1'b1;
      end
      ARB_LK: begin
        // m1 keeps the bus unless its budget is exhausted and m0 is waiting
        if (req1 && !(cnt_hit && req0)) gnt1_c = 1'b1;
        else if (req0)                  gnt0_c = 1'b1;
      end
      default: begin
        if (req0)      gnt0_c = 1'b1;
        else if (req1) gnt1_c = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Two-master arbiter in front of the single-port data memory.
// Optional misalignment trapping is enabled with `define ALIGN_CHK_EN.
module dmem_arbiter
  import dmem_arbiter_pkg::*;
#(
  parameter int unsigned LOCK_MAX = LOCK_MAX_DEF,
  parameter int unsigned CNT_W    = CNT_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,

  input  logic              m0_req,
  input  logic              m0_we,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [RWT_W-1:0]  m0_rw_type,
  input  logic [DATA_W-1:0] m0_wdata,
  output logic              m0_gnt,
  output logic              m0_rvalid,
  output logic [DATA_W-1:0] m0_rdata,
  output logic              m0_err,

  input  logic              m1_req,
  input  logic              m1_we,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [RWT_W-1:0]  m1_rw_type,
  input  logic [DATA_W-1:0] m1_wdata,
  input  logic              m1_lock,
  output logic              m1_gnt,
  output logic              m1_rvalid,
  output logic [DATA_W-1:0] m1_rdata,
  output logic              m1_err,

  output logic              mem_W_en,
  output logic              mem_R_en,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [RWT_W-1:0]  mem_RW_type,
  output logic [DATA_W-1:0] mem_din,
  input  logic [DATA_W-1:0] mem_dout
);

  arb_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             cnt_hit_c;
  logic             gnt0_c, gnt1_c;
  logic             any_gnt_c;
  logic             mis_c;
  logic             rsp0_c, rsp1_c;
  mem_req_t         m0_p, m1_p, sel_c;

  assign cnt_hit_c = (cnt_q == CNT_W'(LOCK_MAX));

  rr_arb2 u_pick (
    .req0    (m0_req),
    .req1    (m1_req),
    .state   (state_q),
    .cnt_hit (cnt_hit_c),
    .gnt0_c  (gnt0_c),
    .gnt1_c  (gnt1_c)
  );

  // No grants while reset is asserted, so nothing reaches the memory
  assign m0_gnt    = rst_n & gnt0_c;
  assign m1_gnt    = rst_n & gnt1_c;
  assign any_gnt_c = m0_gnt | m1_gnt;

  assign m0_p  = '{we: m0_we, addr: m0_addr, rw_type: m0_rw_type, wdata: m0_wdata};
  assign m1_p  = '{we: m1_we, addr: m1_addr, rw_type: m1_rw_type, wdata: m1_wdata};
  assign sel_c = m1_gnt ? m1_p : m0_p;

`ifdef ALIGN_CHK_EN
  assign mis_c = misaligned(sel_c.rw_type[1:0], sel_c.addr[1:0]);
`else
  assign mis_c = 1'b0;
`endif

  // Memory-side mux: winner fields, everything zero when idle
  always_comb begin
    mem_W_en    = 1'b0;
    mem_R_en    = 1'b0;
    mem_addr    = '0;
    mem_RW_type = '0;
    mem_din     = '0;
    if (any_gnt_c) begin
      mem_addr    = sel_c.addr;
      mem_RW_type = sel_c.rw_type;
      mem_din     = sel_c.wdata;
      mem_W_en    = sel_c.we & ~mis_c;
      mem_R_en    = ~sel_c.we & ~mis_c;
    end
  end

  // Next-state and lock budget; the grant that opens a burst counts as its first cycle
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ARB_P0, ARB_P1: begin
        if (m1_gnt) begin
          state_d = m1_lock ? ARB_LK : ARB_P0;
          cnt_d   = m1_lock ? CNT_W'(1) : '0;
        end else if (m0_gnt) begin
          state_d = ARB_P1;
        end
      end
      ARB_LK: begin
        if (m1_gnt && m1_lock) begin
          if (!cnt_hit_c) cnt_d = cnt_q + CNT_W'(1);
        end else begin
          cnt_d   = '0;
          // m1 still asking but not granted means a forced release to m0
          state_d = (m1_req && !m1_gnt) ? ARB_P1 : ARB_P0;
        end
      end
      default: begin
        state_d = ARB_P0;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ARB_P0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Loads and trapped accesses answer one cycle after the grant
  assign rsp0_c = m0_gnt & (~sel_c.we | mis_c);
  assign rsp1_c = m1_gnt & (~sel_c.we | mis_c);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      m0_rvalid <= 1'b0;
      m0_rdata  <= ZERO_WORD;
      m0_err    <= 1'b0;
      m1_rvalid <= 1'b0;
      m1_rdata  <= ZERO_WORD;
      m1_err    <= 1'b0;
    end else begin
      m0_rvalid <= rsp0_c;
      m0_err    <= m0_gnt & mis_c;
      if (rsp0_c) m0_rdata <= mis_c ? ZERO_WORD : mem_dout;
      m1_rvalid <= rsp1_c;
      m1_err    <= m1_gnt & mis_c;
      if (rsp1_c) m1_rdata <= mis_c ? ZERO_WORD : mem_dout;
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: word memory model, byte-level shadow
// scoreboard checked every cycle, plus directed scenarios with literal values.
module tb_dmem_arbiter;

  localparam int unsigned LMAX = 16;
`ifdef ALIGN_CHK_EN
  localparam bit ALIGN = 1'b1;
`else
  localparam bit ALIGN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        m0_req, m0_we, m0_gnt, m0_rvalid, m0_err;
  logic [31:0] m0_addr, m0_wdata, m0_rdata;
  logic [2:0]  m0_rw_type;
  logic        m1_req, m1_we, m1_gnt, m1_rvalid, m1_err, m1_lock;
  logic [31:0] m1_addr, m1_wdata, m1_rdata;
  logic [2:0]  m1_rw_type;
  logic        mem_W_en, mem_R_en;
  logic [31:0] mem_addr, mem_din, mem_dout;
  logic [2:0]  mem_RW_type;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  dmem_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_rw_type(m0_rw_type),
    .m0_wdata(m0_wdata), .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
    .m0_err(m0_err),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_rw_type(m1_rw_type),
    .m1_wdata(m1_wdata), .m1_lock(m1_lock), .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid),
    .m1_rdata(m1_rdata), .m1_err(m1_err),
    .mem_W_en(mem_W_en), .mem_R_en(mem_R_en), .mem_addr(mem_addr),
    .mem_RW_type(mem_RW_type), .mem_din(mem_din), .mem_dout(mem_dout)
  );

  task automatic chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- word-organised memory (environment) ----------------
  logic [31:0] ram [0:63];
  logic [31:0] rd_word;
  logic [7:0]  rd_byte;
  logic [15:0] rd_half;

  function automatic logic [31:0] init_word(input int i);
    if (i == 4) return 32'hDEADBEEF;
    if (i == 8) return 32'h11223344;
    return 32'h5A00_00C3 ^ 32'(i * 32'h0001_0101);
  endfunction

  always_comb begin
    rd_word = ram[mem_addr[7:2]];
    rd_byte = rd_word[{mem_addr[1:0], 3'b000} +: 8];
    rd_half = mem_addr[1] ? rd_word[31:16] : rd_word[15:0];
    case (mem_RW_type[1:0])
      2'b00:   mem_dout = mem_RW_type[2] ? {24'h0, rd_byte} : {{24{rd_byte[7]}}, rd_byte};
      2'b01:   mem_dout = mem_RW_type[2] ? {16'h0, rd_half} : {{16{rd_half[15]}}, rd_half};
      default: mem_dout = rd_word;
    endcase
  end

  always @(posedge clk) begin
    if (mem_W_en) begin
      case (mem_RW_type[1:0])
        2'b00: ram[mem_addr[7:2]][{mem_addr[1:0], 3'b000} +: 8] <= mem_din[7:0];
        2'b01: begin
          if (mem_addr[1]) ram[mem_addr[7:2]][31:16] <= mem_din[15:0];
          else             ram[mem_addr[7:2]][15:0]  <= mem_din[15:0];
        end
        default: ram[mem_addr[7:2]] <= mem_din;
      endcase
    end
  end

  // ---------------- reference model: byte shadow + arbitration history ----------------
  logic [7:0] sh [0:255];

  function automatic logic model_mis(input logic [31:0] a, input logic [2:0] t);
    logic raw;
    raw = (t[1:0] == 2'b01 && a[0]) || (t[1:0] == 2'b10 && a[1:0] != 2'b00);
    return ALIGN && raw;
  endfunction

  function automatic logic [31:0] model_load(input logic [31:0] a, input logic [2:0] t);
    logic [7:0] b;
    logic [7:0] base;
    logic [15:0] h;
    case (t[1:0])
      2'b00: begin
        b = sh[a[7:0]];
        return t[2] ? {24'h0, b} : {{24{b[7]}}, b};
      end
      2'b01: begin
        base = {a[7:1], 1'b0};
        h = {sh[base + 8'd1], sh[base]};
        return t[2] ? {16'h0, h} : {{16{h[15]}}, h};
      end
      default: begin
        base = {a[7:2], 2'b00};
        return {sh[base + 8'd3], sh[base + 8'd2], sh[base + 8'd1], sh[base]};
      end
    endcase
  endfunction

  task automatic model_store(input logic [31:0] a, input logic [2:0] t, input logic [31:0] d);
    logic [7:0] base;
    case (t[1:0])
      2'b00: sh[a[7:0]] = d[7:0];
      2'b01: begin
        base = {a[7:1], 1'b0};
        sh[base] = d[7:0];
        sh[base + 8'd1] = d[15:8];
      end
      default: begin
        base = {a[7:2], 2'b00};
        for (int k = 0; k < 4; k++) sh[base + 8'(k)] = d[8*k +: 8];
      end
    endcase
  endtask

  logic        exp_rv0, exp_rv1, exp_err0, exp_err1;
  logic [31:0] exp_rd0, exp_rd1;
  logic        pref_m1, locked, live;
  int          burst;

  initial begin
    live = 1'b0; pref_m1 = 1'b0; locked = 1'b0; burst = 0;
    exp_rv0 = 1'b0; exp_rv1 = 1'b0; exp_err0 = 1'b0; exp_err1 = 1'b0;
    exp_rd0 = '0; exp_rd1 = '0;
  end

  always @(negedge clk) begin : cmp
    logic        w0, w1, we, mis;
    logic [31:0] a, d;
    logic [2:0]  t;
    if (live) begin
      chk1("m0_rvalid", m0_rvalid, exp_rv0);
      chk1("m1_rvalid", m1_rvalid, exp_rv1);
      chk1("m0_err", m0_err, exp_err0);
      chk1("m1_err", m1_err, exp_err1);
      if (exp_rv0) chk32("m0_rdata", m0_rdata, exp_rd0);
      if (exp_rv1) chk32("m1_rdata", m1_rdata, exp_rd1);
    end
    // who must win this cycle
    w0 = 1'b0; w1 = 1'b0;
    if (rst_n) begin
      if (locked) begin
        if (m1_req && !(burst >= LMAX && m0_req)) w1 = 1'b1;
        else if (m0_req)                          w0 = 1'b1;
      end else if (pref_m1) begin
        if (m1_req)      w1 = 1'b1;
        else if (m0_req) w0 = 1'b1;
      end else begin
        if (m0_req)      w0 = 1'b1;
        else if (m1_req) w1 = 1'b1;
      end
    end
    if (w0 | w1) begin
      we = w1 ? m1_we : m0_we;
      a  = w1 ? m1_addr : m0_addr;
      t  = w1 ? m1_rw_type : m0_rw_type;
      d  = w1 ? m1_wdata : m0_wdata;
      mis = model_mis(a, t);
    end else begin
      we = 1'b0; a = '0; t = '0; d = '0; mis = 1'b0;
    end
    chk1("m0_gnt", m0_gnt, w0);
    chk1("m1_gnt", m1_gnt, w1);
    chk1("mem_W_en", mem_W_en, (w0 | w1) & we & ~mis);
    chk1("mem_R_en", mem_R_en, (w0 | w1) & ~we & ~mis);
    chk32("mem_addr", mem_addr, a);
    chk32("mem_RW_type", 32'(mem_RW_type), 32'(t));
    chk32("mem_din", mem_din, d);
    // advance model to the next edge
    if (!rst_n) begin
      exp_rv0 = 1'b0; exp_rv1 = 1'b0; exp_err0 = 1'b0; exp_err1 = 1'b0;
      exp_rd0 = '0; exp_rd1 = '0;
      pref_m1 = 1'b0; locked = 1'b0; burst = 0;
      live = 1'b1;
    end else begin
      exp_rv0 = w0 & (~we | mis);
      exp_rv1 = w1 & (~we | mis);
      exp_err0 = w0 & mis;
      exp_err1 = w1 & mis;
      if (exp_rv0) exp_rd0 = mis ? 32'h0 : model_load(a, t);
      if (exp_rv1) exp_rd1 = mis ? 32'h0 : model_load(a, t);
      if ((w0 | w1) && we && !mis) model_store(a, t, d);
      if (locked) begin
        if (w1 && m1_lock) begin
          if (burst < LMAX) burst++;
        end else begin
          locked = 1'b0; burst = 0;
          pref_m1 = m1_req && !w1;
        end
      end else if (w1) begin
        pref_m1 = 1'b0;
        if (m1_lock) begin locked = 1'b1; burst = 1; end
      end else if (w0) begin
        pref_m1 = 1'b1;
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    m0_req = 1'b0; m1_req = 1'b0; m1_lock = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; idle(); step(); step(); rst_n = 1'b1;
  endtask

  task automatic set_m0(input logic we, input logic [31:0] a, input logic [2:0] t, input logic [31:0] d);
    m0_we = we; m0_addr = a; m0_rw_type = t; m0_wdata = d;
  endtask

  task automatic set_m1(input logic we, input logic [31:0] a, input logic [2:0] t, input logic [31:0] d);
    m1_we = we; m1_addr = a; m1_rw_type = t; m1_wdata = d;
  endtask

  // One m0 access alone on the bus; returns the response seen the cycle after grant
  task automatic m0_access(input logic we, input logic [31:0] a, input logic [2:0] t,
                           input logic [31:0] d, output logic ren, output logic rv,
                           output logic [31:0] rd, output logic er);
    int n;
    n = 0;
    set_m0(we, a, t, d);
    m0_req = 1'b1;
    @(negedge clk);
    while (!m0_gnt && n < 20) begin step(); @(negedge clk); n++; end
    if (!m0_gnt) chk1("m0_gnt_timeout", m0_gnt, 1'b1);
    ren = mem_R_en;
    step();
    m0_req = 1'b0;
    @(negedge clk);
    rv = m0_rvalid; rd = m0_rdata; er = m0_err;
    step();
  endtask

  logic [31:0] ta [4] = '{32'h13, 32'h13, 32'h12, 32'h10};
  logic [2:0]  tt [4] = '{3'b000, 3'b100, 3'b001, 3'b101};
  logic [31:0] te [4] = '{32'hFFFFFFDE, 32'h000000DE, 32'hFFFFDEAD, 32'h0000BEEF};

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic        ren, rv, er;
    logic [31:0] rd;
    int n1, run, gap, maxrun;
    int runs[$];
    int gaps[$];

    for (int i = 0; i < 64; i++) ram[i] = init_word(i);
    for (int i = 0; i < 256; i++) sh[i] = init_word(i / 4)[8*(i%4) +: 8];
    rst_n = 1'b0; idle();
    set_m0(1'b0, '0, '0, '0);
    set_m1(1'b0, '0, '0, '0);
    do_reset();

    // basic load
    m0_access(1'b0, 32'h10, 3'b010, 32'h0, ren, rv, rd, er);
    chk1("s1_ren", ren, 1'b1);
    chk1("s1_rvalid", rv, 1'b1);
    chk32("s1_rdata", rd, 32'hDEADBEEF);
    chk1("s1_err", er, 1'b0);

    // both requesting without lock alternate, m0 first
    do_reset();
    set_m0(1'b0, 32'h14, 3'b010, 32'h0);
    set_m1(1'b0, 32'h18, 3'b010, 32'h0);
    m0_req = 1'b1; m1_req = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk1("alt_m0", m0_gnt, (i % 2) == 0);
      chk1("alt_m1", m1_gnt, (i % 2) == 1);
      step();
    end
    idle(); step(); step();

    // locked burst of 40 stores against a continuously waiting m0
    do_reset();
    n1 = 0; run = 0; gap = 0; maxrun = 0;
    set_m0(1'b0, 32'h10, 3'b010, 32'h0);
    set_m1(1'b1, 32'h40, 3'b010, 32'h0);
    m1_lock = 1'b1; m1_req = 1'b1;
    for (int c = 0; c < 120 && n1 < 40; c++) begin
      m1_addr  = 32'h40 + 32'(4 * (n1 % 8));
      m1_wdata = 32'hB000_0000 + 32'(n1);
      m0_req   = (c >= 1);
      @(negedge clk);
      if (m1_gnt) begin
        n1++; run++;
        if (gap > 0) begin gaps.push_back(gap); gap = 0; end
      end else if (m0_gnt) begin
        gap++;
        if (run > 0) begin runs.push_back(run); if (run > maxrun) maxrun = run; run = 0; end
      end
      step();
    end
    if (run > 0) begin runs.push_back(run); if (run > maxrun) maxrun = run; end
    idle(); step();
    chk32("burst_count", 32'(n1), 32'd40);
    chk32("burst_nruns", 32'(runs.size()), 32'd3);
    if (runs.size() == 3) begin
      chk32("burst_run0", 32'(runs[0]), 32'd16);
      chk32("burst_run1", 32'(runs[1]), 32'd16);
      chk32("burst_run2", 32'(runs[2]), 32'd8);
    end
    if (gaps.size() > 0) chk32("burst_gap0", 32'(gaps[0]), 32'd1);
    else chk32("burst_gap_missing", 32'(gaps.size()), 32'd1);
    chk1("burst_max_ok", maxrun <= 16, 1'b1);
    m0_access(1'b0, 32'h40, 3'b010, 32'h0, ren, rv, rd, er);
    chk32("burst_last_word", rd, 32'hB000_0020);

    // simultaneous store/load to the same byte: m0 wins and reads the old byte
    do_reset();
    set_m1(1'b1, 32'h21, 3'b000, 32'h0000_00AA);
    set_m0(1'b0, 32'h21, 3'b100, 32'h0);
    m0_req = 1'b1; m1_req = 1'b1;
    @(negedge clk);
    chk1("rw_m0_gnt", m0_gnt, 1'b1);
    chk1("rw_m1_wait", m1_gnt, 1'b0);
    step(); m0_req = 1'b0;
    @(negedge clk);
    chk1("rw_rvalid", m0_rvalid, 1'b1);
    chk32("rw_old_byte", m0_rdata, 32'h0000_0033);
    chk1("rw_m1_gnt", m1_gnt, 1'b1);
    step(); m1_req = 1'b0;
    m0_access(1'b0, 32'h21, 3'b100, 32'h0, ren, rv, rd, er);
    chk32("rw_new_byte", rd, 32'h0000_00AA);

    // sign/zero extension table
    for (int i = 0; i < 4; i++) begin
      m0_access(1'b0, ta[i], tt[i], 32'h0, ren, rv, rd, er);
      chk32("ext_rdata", rd, te[i]);
    end

    // misaligned word load
    m0_access(1'b0, 32'h22, 3'b010, 32'h0, ren, rv, rd, er);
    chk1("mis_rvalid", rv, 1'b1);
    chk1("mis_ren", ren, !ALIGN);
    chk1("mis_err", er, ALIGN);
    chk32("mis_rdata", rd, ALIGN ? 32'h0 : 32'h1122AA44);

    // reset during a pending access; arbiter restarts with m0 priority
    do_reset();
    set_m0(1'b0, 32'h10, 3'b010, 32'h0);
    set_m1(1'b0, 32'h14, 3'b010, 32'h0);
    m0_req = 1'b1;
    @(negedge clk);
    chk1("rst_pre_gnt", m0_gnt, 1'b1);
    step(); rst_n = 1'b0; m1_req = 1'b1;
    @(negedge clk);
    chk1("rst_m0_gnt", m0_gnt, 1'b0);
    chk1("rst_m1_gnt", m1_gnt, 1'b0);
    chk1("rst_ren", mem_R_en, 1'b0);
    step(); rst_n = 1'b1;
    @(negedge clk);
    chk1("rst_rvalid_dropped", m0_rvalid, 1'b0);
    chk1("rst_p0_m0", m0_gnt, 1'b1);
    chk1("rst_p0_m1", m1_gnt, 1'b0);
    step(); idle();
    @(negedge clk);
    chk32("rst_after_rdata", m0_rdata, 32'hDEADBEEF);
    step();

    // lock counter saturates while m0 idle; m0 then wins on its first cycle
    do_reset();
    set_m1(1'b0, 32'h14, 3'b010, 32'h0);
    m1_lock = 1'b1; m1_req = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk1("sat_m1_gnt", m1_gnt, 1'b1);
      step();
    end
    set_m0(1'b0, 32'h10, 3'b010, 32'h0);
    m0_req = 1'b1;
    @(negedge clk);
    chk1("sat_release_m0", m0_gnt, 1'b1);
    chk1("sat_release_m1", m1_gnt, 1'b0);
    step(); m0_req = 1'b0;
    @(negedge clk);
    chk1("sat_m1_back", m1_gnt, 1'b1);
    step(); idle(); step(); step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
